bus_uart_tx: RTL

//  Memory-mapped UART transmitter on the CPU core's data bus, downstream of the core.
//  - Consumes core write cycles (RW=0) at BASE and queues the bytes in a small FIFO.
//  - Serialises them as 8N1 frames on tx.
//  - Returns status on core read cycles via a combinational read port.
//  - The bus-level read mux selects this block's D_out when hit=1.

---
 rtl/bus_uart_tx_pkg.sv | 31 +++
 rtl/bus_uart_tx_fifo.sv | 56 +++++
 rtl/bus_uart_tx.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/bus_uart_tx_pkg.sv
// Shared definitions for the bus-mapped UART transmitter: FSM states, register
// offsets, STATUS bit positions and a STATUS packing helper.
package bus_uart_tx_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  localparam logic [15:0] RegData   = 16'd0;
  localparam logic [15:0] RegStatus = 16'd1;

  localparam int unsigned StatusBusy  = 0;
  localparam int unsigned StatusFull  = 1;
  localparam int unsigned StatusEmpty = 2;
  localparam int unsigned StatusOvf   = 3;

  function automatic logic [7:0] status_pack(input logic busy, input logic full,
                                             input logic empty, input logic ovf);
    logic [7:0] s;
    s              = 8'h00;
    s[StatusBusy]  = busy;
    s[StatusFull]  = full;
    s[StatusEmpty] = empty;
    s[StatusOvf]   = ovf;
    return s;
  endfunction

endpackage

// File: rtl/bus_uart_tx_fifo.sv
// Small synchronous FIFO queueing bytes for the UART serialiser.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module bus_uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LOG2  = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned DEPTH = 1 << LOG2;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LOG2-1:0]  r_wr_ptr;
  logic [LOG2-1:0]  r_rd_ptr;
  logic [LOG2:0]    r_count;

  logic w_push_ok;
  logic w_pop_ok;

  always_comb begin
    o_full    = (r_count == (LOG2 + 1)'(DEPTH));
    o_empty   = (r_count == '0);
    o_dout    = r_mem[r_rd_ptr];
    w_pop_ok  = i_pop && !o_empty;
    w_push_ok = i_push && (!o_full || w_pop_ok);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop_ok) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push_ok && w_pop_ok) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: address decode, STATUS read mux, sticky
// overflow flag and the serialiser FSM driving a registered tx line.
module bus_uart_tx
  import bus_uart_tx_pkg::*;
#(
  parameter logic [15:0] BASE      = 16'hD000,
  parameter int unsigned CLK_DIV   = 104,
  parameter int unsigned FIFO_LOG2 = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rw,
  input  logic [15:0] i_ad,
  input  logic [7:0]  i_d_in,
  output logic [7:0]  o_d_out,
  output logic        o_hit,
  output logic        o_tx
);

  localparam logic [15:0] DataAddr   = BASE + RegData;
  localparam logic [15:0] StatusAddr = BASE + RegStatus;
  localparam logic [15:0] BaudLast   = 16'(CLK_DIV - 1);

  tx_state_e   r_state;
  tx_state_e   w_state_nxt;
  logic [15:0] r_baud_cnt;
  logic [15:0] w_baud_cnt_nxt;
  logic [2:0]  r_bit_idx;
  logic [2:0]  w_bit_idx_nxt;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_nxt;
  logic        r_tx;
  logic        w_tx_nxt;
  logic        r_ovf;

  logic        w_sel_data;
  logic        w_sel_status;
  logic        w_push;
  logic        w_pop;
  logic        w_ovf_clr;
  logic        w_full;
  logic        w_empty;
  logic [7:0]  w_fifo_dout;
  logic        w_bit_done;
  logic [7:0]  w_status;
  logic        w_unused_d_in;

  always_comb begin
    w_sel_data    = (i_ad == DataAddr);
    w_sel_status  = (i_ad == StatusAddr);
    o_hit         = w_sel_data || w_sel_status;
    w_push        = !i_rw && w_sel_data;
    w_ovf_clr     = !i_rw && w_sel_status && i_d_in[StatusOvf];
    w_unused_d_in = ^{i_d_in[7:4], i_d_in[2:0]};
    w_status      = status_pack((r_state != StIdle) || !w_empty, w_full, w_empty, r_ovf);
    o_d_out       = 8'h00;
    if (i_rw && w_sel_status) o_d_out = w_status;
  end

  bus_uart_tx_fifo #(
    .WIDTH (8),
    .LOG2  (FIFO_LOG2)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (i_d_in),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A dropped push is one that arrives full with no pop freeing a slot.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  // tx is loaded with the level of the state being entered, so it is registered.
  always_comb begin
    w_state_nxt    = r_state;
    w_baud_cnt_nxt = r_baud_cnt + 16'd1;
    w_bit_idx_nxt  = r_bit_idx;
    w_shift_nxt    = r_shift;
    w_tx_nxt       = r_tx;
    w_pop          = 1'b0;
    w_bit_done     = (r_baud_cnt == BaudLast);
    case (r_state)
      StIdle: begin
        w_baud_cnt_nxt = '0;
        w_tx_nxt       = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_dout;
          w_state_nxt = StStart;
          w_tx_nxt    = 1'b0;
        end
      end
      StStart: begin
        if (w_bit_done) begin
          w_baud_cnt_nxt = '0;
          w_bit_idx_nxt  = '0;
          w_state_nxt    = StData;
          w_tx_nxt       = r_shift[0];
        end
      end
      StData: begin
        if (w_bit_done) begin
          w_baud_cnt_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = StStop;
            w_tx_nxt    = 1'b1;
          end else begin
            w_shift_nxt   = {1'b0, r_shift[7:1]};
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_tx_nxt      = r_shift[1];
          end
        end
      end
      StStop: begin
        if (w_bit_done) begin
          w_baud_cnt_nxt = '0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_dout;
            w_state_nxt = StStart;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = StIdle;
            w_tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  assign o_tx = r_tx;

endmodule
